// File: rtl/muldiv_pkg.sv
// Shared types for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam int MULDIV_WIDTH = 32;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide on magnitudes.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] next_acc
);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH:0]     trial;

  always_comb begin
    // Multiply: acc = {product_hi, multiplier/product_lo}; the add carry is shifted back in.
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: acc = {rem, quot}; the shifted remainder needs one extra bit.
    rem_s  = acc[2*WIDTH-1:WIDTH-1];
    quot_s = {acc[WIDTH-2:0], 1'b0};
    trial  = rem_s - {1'b0, operand};

    next_acc = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (trial[WIDTH])
        next_acc = {rem_s[WIDTH-1:0], quot_s};
      else
        next_acc = {trial[WIDTH-1:0], quot_s[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer: one bit per clock, sign fix-up, then HI/LO update.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  muldiv_state_t      state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic               sign_a;
  logic               sign_b;
  logic               is_div;

  logic               op_signed;
  logic               op_div;
  logic               in_sa;
  logic               in_sb;
  logic [WIDTH-1:0]   in_ma;
  logic [WIDTH-1:0]   in_mb;

  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_s;
  logic               neg;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic               fix_dz;

  always_comb begin
    op_signed = (op == MULT) || (op == DIV);
    op_div    = (op == DIV) || (op == DIVU);
    in_sa     = op_signed & a[WIDTH-1];
    in_sb     = op_signed & b[WIDTH-1];
    in_ma     = in_sa ? -a : a;
    in_mb     = in_sb ? -b : b;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (operand),
    .next_acc (step_acc)
  );

  // Divide-by-zero skips RUN, so acc[WIDTH-1:0] still holds |a| and re-signing it restores a.
  always_comb begin
    neg    = sign_a ^ sign_b;
    prod_s = neg ? -acc : acc;
    fix_hi = prod_s[2*WIDTH-1:WIDTH];
    fix_lo = prod_s[WIDTH-1:0];
    fix_dz = 1'b0;
    if (is_div) begin
      if (operand == '0) begin
        fix_hi = sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_lo = '1;
        fix_dz = 1'b1;
      end else begin
        fix_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_lo = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      is_div  <= 1'b0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            sign_a  <= in_sa;
            sign_b  <= in_sb;
            is_div  <= op_div;
            cnt     <= '0;
            operand <= op_div ? in_mb : in_ma;
            acc     <= {{WIDTH{1'b0}}, (op_div ? in_ma : in_mb)};
            state   <= (op_div && (b == '0)) ? FIX : RUN;
          end
        end
        RUN: begin
          acc <= step_acc;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          dz    <= fix_dz;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomized checks of muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = MULDIV_WIDTH;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  muldiv_op_t   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         dz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {dz, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [2*W:0] model(input muldiv_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
    int          si;
    int          sj;
    longint      p;
    longint      q;
    longint      r;
    logic [63:0] u;
    si = x;
    sj = y;
    case (o)
      MULT: begin
        p = longint'(si) * longint'(sj);
        u = p;
        return {1'b0, u};
      end
      MULTU: begin
        u = {32'b0, x} * {32'b0, y};
        return {1'b0, u};
      end
      DIV: begin
        if (y == 0) return {1'b1, x, {W{1'b1}}};
        q = longint'(si) / longint'(sj);
        r = longint'(si) % longint'(sj);
        return {1'b0, r[W-1:0], q[W-1:0]};
      end
      default: begin
        if (y == 0) return {1'b1, x, {W{1'b1}}};
        return {1'b0, x % y, x / y};
      end
    endcase
  endfunction

  task automatic scramble();
    a  = $urandom;
    b  = $urandom;
    op = muldiv_op_t'($urandom_range(0, 3));
  endtask

  // Caller is at a negedge; b2b means the current cycle is a DONE cycle.
  task automatic run_op(input muldiv_op_t o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit noise, input bit b2b, input string tag);
    int          n;
    int          busy_cnt;
    bit          got;
    int          exp_lat;
    logic [2*W:0] m;
    if (!b2b) @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
    exp_lat  = (((o == DIV) || (o == DIVU)) && (y == 0)) ? 1 : W + 1;
    n        = 0;
    busy_cnt = 0;
    got      = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (noise) begin
        if (n >= 3 && n <= 5) begin
          scramble();
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
      if (done) got = 1'b1;
      else if (busy) busy_cnt++;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_latency"}, 64'(n - 1), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    m = model(o, x, y);
    chk({tag, "_hi"}, 64'(hi), 64'(m[2*W-1:W]));
    chk({tag, "_lo"}, 64'(lo), 64'(m[W-1:0]));
    chk({tag, "_dz"}, 64'(dz), 64'(m[2*W]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = MULTU;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz",   64'(dz),   64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    reset = 1'b0;

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_max");
    chk("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max_lo_const", 64'(lo), 64'h0000_0001);

    run_op(MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, "mult_neg");
    chk("mult_neg_lo_const", 64'(lo), 64'hFFFF_FFEB);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("hold_hi", 64'(hi), 64'hFFFF_FFFF);
    run_op(MULT, 32'd0, 32'h1234, 1'b0, 1'b0, "mult_zero");

    run_op(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_neg");
    chk("div_neg_lo_const", 64'(lo), 64'hFFFF_FFFD);
    run_op(DIVU, 32'd100, 32'd7, 1'b0, 1'b0, "divu_100_7");
    chk("divu_100_7_lo_const", 64'(lo), 64'd14);

    run_op(DIVU, 32'd100, 32'd0, 1'b0, 1'b0, "divu_zero");
    chk("divu_zero_lo_const", 64'(lo), 64'hFFFF_FFFF);
    run_op(MULTU, 32'd2, 32'd3, 1'b0, 1'b0, "multu_after_dz");
    run_op(DIV, 32'h8000_0000, 32'd0, 1'b0, 1'b0, "div_neg_zero");

    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
    chk("div_ovf_lo_const", 64'(lo), 64'h8000_0000);

    run_op(DIV, 32'd12345, 32'hFFFF_FFF0, 1'b1, 1'b0, "noise_div");
    run_op(MULT, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, "noise_mult");

    run_op(MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, "b2b_first");
    run_op(DIV, 32'hF000_0001, 32'd3, 1'b0, 1'b1, "b2b_second");
    run_op(DIVU, 32'd55, 32'd0, 1'b0, 1'b1, "b2b_dz");

    @(negedge clk);
    op = MULTU; a = 32'h7; b = 32'h9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrun_rst_busy", 64'(busy), 64'd0);
    chk("midrun_rst_done", 64'(done), 64'd0);
    chk("midrun_rst_hi",   64'(hi),   64'd0);
    chk("midrun_rst_lo",   64'(lo),   64'd0);
    chk("midrun_rst_dz",   64'(dz),   64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(MULTU, 32'd5, 32'd5, 1'b0, 1'b0, "after_rst");
    chk("after_rst_lo_const", 64'(lo), 64'd25);

    for (int unsigned i = 0; i < 24; i++) begin
      muldiv_op_t   ro;
      logic [W-1:0] rx;
      logic [W-1:0] ry;
      ro = muldiv_op_t'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 3) == 0) ry = W'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rx = W'($urandom_range(0, 255));
      run_op(ro, rx, ry, 1'b0, (i % 3 == 2), $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
